iob_rr_arb: RTL and testbench

//  Round-robin arbiter that shares one iob slave port (e.g. the iob-to-APB bridge) between NREQ iob masters.
//  One transaction is in flight at a time; grant is held from selection until the slave returns ibrdy.

---
 rtl/iob_rr_arb_pkg.sv | 17 +
 rtl/iob_rr_arb_rr_pick.sv | 29 ++
 rtl/iob_rr_arb.sv | 112 +++++++++++
 tb/tb_iob_rr_arb.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_rr_arb_pkg.sv
// Shared iob field widths, arbiter state encoding and grant-index width helper.
package iob_rr_arb_pkg;

  localparam int ADR_W = 32;
  localparam int WEN_W = 4;
  localparam int DAT_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  function automatic int idw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iob_rr_arb_rr_pick.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping at NREQ-1.
module iob_rr_arb_rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [IDW-1:0]  o_win,
  output logic            o_any
);

  logic [IDW:0] w_cand;

  // Walk the offsets from farthest to nearest so the nearest hit is assigned last.
  always_comb begin
    o_win  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = {1'b0, i_ptr} + (IDW+1)'(k);
      if (w_cand >= (IDW+1)'(NREQ)) w_cand = w_cand - (IDW+1)'(NREQ);
      if (i_req[w_cand[IDW-1:0]]) begin
        o_win = w_cand[IDW-1:0];
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_rr_arb.sv
// Round-robin arbiter sharing one iob slave between NREQ iob masters, one transaction in flight.
module iob_rr_arb
  import iob_rr_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = idw_of(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       s_ibval,
  output logic [NREQ-1:0]       s_ibrdy,
  input  logic [NREQ*ADR_W-1:0] s_ibadr,
  input  logic [NREQ*WEN_W-1:0] s_ibwen,
  input  logic [NREQ*DAT_W-1:0] s_ibwdat,
  output logic [DAT_W-1:0]      s_ibrdat,
  output logic                  m_ibval,
  input  logic                  m_ibrdy,
  output logic [ADR_W-1:0]      m_ibadr,
  output logic [WEN_W-1:0]      m_ibwen,
  output logic [DAT_W-1:0]      m_ibwdat,
  input  logic [DAT_W-1:0]      m_ibrdat,
  output logic [IDW-1:0]        gnt_id
);

  arb_state_t     r_state, w_state_next;
  logic [IDW-1:0] r_gnt_id, w_gnt_id_next;
  logic [IDW-1:0] r_ptr, w_ptr_next;
  logic [IDW-1:0] w_win;
  logic           w_any;
  logic           w_busy;

  iob_rr_arb_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .i_req (s_ibval),
    .i_ptr (r_ptr),
    .o_win (w_win),
    .o_any (w_any)
  );

  always_comb begin
    w_state_next  = r_state;
    w_gnt_id_next = r_gnt_id;
    w_ptr_next    = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_next  = ST_BUSY;
          w_gnt_id_next = w_win;
        end
      end
      ST_BUSY: begin
        if (m_ibrdy) begin
          w_state_next = ST_IDLE;
          // Explicit wrap so non-power-of-two NREQ never lands on an unused index.
          w_ptr_next   = (r_gnt_id == IDW'(NREQ - 1)) ? '0 : r_gnt_id + IDW'(1);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_gnt_id <= '0;
      r_ptr    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_gnt_id <= w_gnt_id_next;
      r_ptr    <= w_ptr_next;
    end
  end

  assign w_busy   = (r_state == ST_BUSY);
  assign m_ibval  = w_busy;
  assign s_ibrdat = m_ibrdat;
  assign gnt_id   = r_gnt_id;

  // Per-master select feeds an AND-OR chain; the last stage is the muxed field.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_mst
    logic             w_sel;
    logic [ADR_W-1:0] w_adr_acc;
    logic [WEN_W-1:0] w_wen_acc;
    logic [DAT_W-1:0] w_wdat_acc;
    logic [ADR_W-1:0] w_adr_m;
    logic [WEN_W-1:0] w_wen_m;
    logic [DAT_W-1:0] w_wdat_m;

    assign w_sel       = (r_gnt_id == IDW'(gi));
    assign s_ibrdy[gi] = w_busy & m_ibrdy & w_sel;
    assign w_adr_m     = w_sel ? s_ibadr[ADR_W*gi +: ADR_W]  : '0;
    assign w_wen_m     = w_sel ? s_ibwen[WEN_W*gi +: WEN_W]  : '0;
    assign w_wdat_m    = w_sel ? s_ibwdat[DAT_W*gi +: DAT_W] : '0;

    if (gi == 0) begin : g_first
      assign w_adr_acc  = w_adr_m;
      assign w_wen_acc  = w_wen_m;
      assign w_wdat_acc = w_wdat_m;
    end else begin : g_next
      assign w_adr_acc  = g_mst[gi-1].w_adr_acc  | w_adr_m;
      assign w_wen_acc  = g_mst[gi-1].w_wen_acc  | w_wen_m;
      assign w_wdat_acc = g_mst[gi-1].w_wdat_acc | w_wdat_m;
    end
  end

  assign m_ibadr  = g_mst[NREQ-1].w_adr_acc;
  assign m_ibwen  = g_mst[NREQ-1].w_wen_acc;
  assign m_ibwdat = g_mst[NREQ-1].w_wdat_acc;

endmodule

// File: tb/tb_iob_rr_arb.sv
// Self-checking bench for iob_rr_arb: directed scenarios on NREQ=2 and NREQ=3 plus a randomized run against a reference model.
module tb_iob_rr_arb;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // NREQ = 2 instance
  logic [1:0]  v2, r2;
  logic [63:0] adr2, wdat2;
  logic [7:0]  wen2;
  logic [31:0] srdat2, madr2, mwdat2, mrdat2;
  logic [3:0]  mwen2;
  logic        mval2, mrdy2;
  logic [0:0]  gid2;

  // NREQ = 3 instance
  logic [2:0]  v3, r3;
  logic [95:0] adr3, wdat3;
  logic [11:0] wen3;
  logic [31:0] srdat3, madr3, mwdat3, mrdat3;
  logic [3:0]  mwen3;
  logic        mval3, mrdy3;
  logic [1:0]  gid3;

  iob_rr_arb #(.NREQ(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .s_ibval(v2), .s_ibrdy(r2), .s_ibadr(adr2), .s_ibwen(wen2), .s_ibwdat(wdat2), .s_ibrdat(srdat2),
    .m_ibval(mval2), .m_ibrdy(mrdy2), .m_ibadr(madr2), .m_ibwen(mwen2), .m_ibwdat(mwdat2), .m_ibrdat(mrdat2),
    .gnt_id(gid2)
  );

  iob_rr_arb #(.NREQ(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .s_ibval(v3), .s_ibrdy(r3), .s_ibadr(adr3), .s_ibwen(wen3), .s_ibwdat(wdat3), .s_ibrdat(srdat3),
    .m_ibval(mval3), .m_ibrdy(mrdy3), .m_ibadr(madr3), .m_ibwen(mwen3), .m_ibwdat(mwdat3), .m_ibrdat(mrdat3),
    .gnt_id(gid3)
  );

  task automatic do_reset(input logic [1:0] pv2, input logic [2:0] pv3);
    rst_n = 1'b0;
    mrdy2 = 1'b0; mrdy3 = 1'b0;
    v2 = pv2; v3 = pv3;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Slave model for the 2-master instance: wait for m_ibval, answer after lat BUSY cycles.
  task automatic serve2(input int lat, input logic [31:0] rdat, output bit tmo,
                        output logic [0:0] gid, output logic [1:0] rdy, output logic [31:0] rd);
    int waited;
    waited = 0; tmo = 1'b0; gid = '0; rdy = '0; rd = '0;
    #1;
    while (mval2 !== 1'b1 && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    if (waited >= 20) begin tmo = 1'b1; return; end
    gid = gid2;
    repeat (lat - 1) @(negedge clk);
    mrdy2 = 1'b1; mrdat2 = rdat;
    #1;
    rdy = r2; rd = srdat2;
    @(negedge clk);
    mrdy2 = 1'b0;
  endtask

  task automatic serve3(input int lat, output bit tmo, output logic [1:0] gid, output logic [2:0] rdy);
    int waited;
    waited = 0; tmo = 1'b0; gid = '0; rdy = '0;
    #1;
    while (mval3 !== 1'b1 && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    if (waited >= 20) begin tmo = 1'b1; return; end
    gid = gid3;
    repeat (lat - 1) @(negedge clk);
    mrdy3 = 1'b1;
    #1;
    rdy = r3;
    @(negedge clk);
    mrdy3 = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2'b00, 3'b000);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      n_tests++;
      if ({mval2, r2, gid2} !== 4'b0) begin
        n_fail++; $display("FAIL reset_idle2 cyc %0d: got {val,rdy,gid}=%b required 0000", c, {mval2, r2, gid2});
      end
      n_tests++;
      if ({mval3, r3, gid3} !== 6'b0) begin
        n_fail++; $display("FAIL reset_idle3 cyc %0d: got {val,rdy,gid}=%b required 000000", c, {mval3, r3, gid3});
      end
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_single_read();
    int pulses;
    logic [31:0] sampled;
    logic [1:0]  exp_rdy;
    pulses = 0; sampled = '0;
    do_reset(2'b00, 3'b000);
    @(negedge clk);
    v2 = 2'b01; adr2 = '0; adr2[31:0] = 32'h104; wen2 = '0; wdat2 = '0;
    #1;
    n_tests++;
    if (mval2 !== 1'b0) begin n_fail++; $display("FAIL read_arb_cycle: m_ibval=%b required 0", mval2); end
    @(negedge clk); #1;
    n_tests++;
    if (mval2 !== 1'b1) begin n_fail++; $display("FAIL read_val_rise: m_ibval=%b required 1", mval2); end
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) @(negedge clk);
      mrdy2  = (c == 3);
      mrdat2 = (c == 3) ? 32'hDEADBEEF : 32'h0;
      #1;
      exp_rdy = (c == 3) ? 2'b01 : 2'b00;
      if (r2 !== 2'b00) pulses++;
      if (r2[0] === 1'b1) sampled = srdat2;
      n_tests++;
      if (r2 !== exp_rdy || madr2 !== 32'h104) begin
        n_fail++; $display("FAIL read_busy c%0d: rdy=%b adr=%h required rdy=%b adr=00000104", c, r2, madr2, exp_rdy);
      end
    end
    @(negedge clk);
    v2 = 2'b00; mrdy2 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (r2 !== 2'b00) pulses++;
      n_tests++;
      if (mval2 !== 1'b0) begin n_fail++; $display("FAIL read_after c%0d: m_ibval=%b required 0", c, mval2); end
      @(negedge clk);
    end
    n_tests++;
    if (pulses != 1) begin n_fail++; $display("FAIL read_pulse_count: got %0d required 1", pulses); end
    n_tests++;
    if (sampled !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_rdat: got %h required deadbeef", sampled); end
    $display("[TB] test_single_read done");
  endtask

  task automatic test_alternate();
    bit tmo;
    logic [0:0]  gid;
    logic [1:0]  rdy, exp_rdy;
    logic [31:0] rd, rdat;
    adr2 = {32'h0000_0200, 32'h0000_0100}; wen2 = '0; wdat2 = '0;
    do_reset(2'b11, 3'b000);
    for (int t = 0; t < 4; t++) begin
      rdat = $urandom;
      serve2(1 + (t % 2), rdat, tmo, gid, rdy, rd);
      exp_rdy = (t % 2 == 0) ? 2'b01 : 2'b10;
      n_tests++;
      if (tmo) begin n_fail++; $display("FAIL alt_timeout t%0d: no m_ibval within 20 cycles", t); end
      n_tests++;
      if (gid !== 1'(t % 2)) begin n_fail++; $display("FAIL alt_order t%0d: gnt=%0d required %0d", t, gid, t % 2); end
      n_tests++;
      if (rdy !== exp_rdy || rd !== rdat) begin
        n_fail++; $display("FAIL alt_rdy t%0d: rdy=%b rdat=%h required rdy=%b rdat=%h", t, rdy, rd, exp_rdy, rdat);
      end
      $display("[TB] alternate txn %0d gnt=%0d rdy=%b", t, gid, rdy);
    end
    v2 = 2'b00;
  endtask

  task automatic test_write_hold();
    do_reset(2'b00, 3'b000);
    @(negedge clk);
    adr2  = {32'h0000_0008, 32'h0000_0200};
    wen2  = {4'hF, 4'h0};
    wdat2 = {32'h1234_5678, 32'h0};
    v2    = 2'b10;
    @(negedge clk); #1;
    n_tests++;
    if (mval2 !== 1'b1 || gid2 !== 1'b1) begin
      n_fail++; $display("FAIL wr_grant: val=%b gnt=%0d required val=1 gnt=1", mval2, gid2);
    end
    v2 = 2'b11;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_tests++;
      if ({madr2, mwen2, mwdat2, gid2} !== {32'h8, 4'hF, 32'h1234_5678, 1'b1}) begin
        n_fail++; $display("FAIL wr_hold c%0d: adr=%h wen=%h wdat=%h gnt=%0d required 00000008 f 12345678 1",
                           c, madr2, mwen2, mwdat2, gid2);
      end
    end
    @(negedge clk);
    mrdy2 = 1'b1;
    #1;
    n_tests++;
    if (r2 !== 2'b10) begin n_fail++; $display("FAIL wr_rdy: rdy=%b required 10", r2); end
    @(negedge clk);
    mrdy2 = 1'b0; v2 = 2'b01;
    #1;
    n_tests++;
    if (mval2 !== 1'b0) begin n_fail++; $display("FAIL wr_idle_gap: m_ibval=%b required 0", mval2); end
    @(negedge clk); #1;
    n_tests++;
    if (mval2 !== 1'b1 || gid2 !== 1'b0 || madr2 !== 32'h200) begin
      n_fail++; $display("FAIL wr_next_grant: val=%b gnt=%0d adr=%h required 1 0 00000200", mval2, gid2, madr2);
    end
    mrdy2 = 1'b1;
    #1;
    n_tests++;
    if (r2 !== 2'b01) begin n_fail++; $display("FAIL wr_m0_rdy: rdy=%b required 01", r2); end
    @(negedge clk);
    mrdy2 = 1'b0; v2 = 2'b00;
    $display("[TB] test_write_hold done");
  endtask

  task automatic test_wrap3();
    bit tmo;
    logic [1:0] gid;
    logic [2:0] rdy;
    adr3 = '0; wen3 = '0; wdat3 = '0;
    do_reset(3'b000 == 3'b000 ? 2'b00 : 2'b00, 3'b000);
    @(negedge clk);
    v3 = 3'b010;
    serve3(2, tmo, gid, rdy);
    n_tests++;
    if (tmo || gid !== 2'd1 || rdy !== 3'b010) begin
      n_fail++; $display("FAIL wrap_first: tmo=%0d gnt=%0d rdy=%b required 0 1 010", tmo, gid, rdy);
    end
    v3 = 3'b011;
    serve3(1, tmo, gid, rdy);
    n_tests++;
    if (tmo || gid !== 2'd0 || rdy !== 3'b001) begin
      n_fail++; $display("FAIL wrap_m0: tmo=%0d gnt=%0d rdy=%b required 0 0 001", tmo, gid, rdy);
    end
    v3 = 3'b010;
    serve3(1, tmo, gid, rdy);
    n_tests++;
    if (tmo || gid !== 2'd1 || rdy !== 3'b010) begin
      n_fail++; $display("FAIL wrap_m1: tmo=%0d gnt=%0d rdy=%b required 0 1 010", tmo, gid, rdy);
    end
    v3 = 3'b000;
    $display("[TB] test_wrap3 done");
  endtask

  task automatic test_reset_busy();
    bit tmo;
    logic [1:0] gid;
    logic [2:0] rdy;
    do_reset(2'b00, 3'b000);
    @(negedge clk);
    v3 = 3'b010;
    serve3(1, tmo, gid, rdy);
    n_tests++;
    if (tmo || gid !== 2'd1) begin n_fail++; $display("FAIL rstb_setup: tmo=%0d gnt=%0d required 0 1", tmo, gid); end
    v3 = 3'b100;
    @(negedge clk); #1;
    n_tests++;
    if (mval3 !== 1'b1 || gid3 !== 2'd2) begin
      n_fail++; $display("FAIL rstb_busy: val=%b gnt=%0d required 1 2", mval3, gid3);
    end
    v3 = 3'b110;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (mval3 !== 1'b0 || gid3 !== 2'd0 || r3 !== 3'b000) begin
      n_fail++; $display("FAIL rstb_async: val=%b gnt=%0d rdy=%b required 0 0 000", mval3, gid3, r3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (mval3 !== 1'b0) begin n_fail++; $display("FAIL rstb_idle: m_ibval=%b required 0", mval3); end
    @(negedge clk); #1;
    n_tests++;
    if (mval3 !== 1'b1 || gid3 !== 2'd1) begin
      n_fail++; $display("FAIL rstb_ptr0: val=%b gnt=%0d required 1 1", mval3, gid3);
    end
    mrdy3 = 1'b1;
    #1;
    n_tests++;
    if (r3 !== 3'b010) begin n_fail++; $display("FAIL rstb_rdy: rdy=%b required 010", r3); end
    @(negedge clk);
    mrdy3 = 1'b0; v3 = 3'b000;
    $display("[TB] test_reset_busy done");
  endtask

  // Reference model: one grant at a time, winner is nearest requester at or after ptr (mod 3).
  task automatic test_random();
    bit          m_busy;
    int          m_gnt, m_ptr, j;
    bit   [2:0]  done;
    logic [2:0]  exp_rdy;
    logic [31:0] t_adr [3];
    logic [31:0] t_wdat[3];
    logic [3:0]  t_wen [3];
    int          grants[3];
    m_busy = 1'b0; m_gnt = 0; m_ptr = 0; done = '0;
    for (int i = 0; i < 3; i++) begin
      t_adr[i] = '0; t_wdat[i] = '0; t_wen[i] = '0; grants[i] = 0;
    end
    adr3 = '0; wen3 = '0; wdat3 = '0;
    do_reset(2'b00, 3'b000);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (done[i]) begin v3[i] = 1'b0; done[i] = 1'b0; end
        if (!v3[i] && $urandom_range(0, 2) == 0) begin
          t_adr[i]  = $urandom;
          t_wdat[i] = $urandom;
          t_wen[i]  = 4'($urandom_range(0, 15));
          adr3[32*i +: 32] = t_adr[i];
          wdat3[32*i +: 32] = t_wdat[i];
          wen3[4*i +: 4]   = t_wen[i];
          v3[i] = 1'b1;
        end
      end
      mrdy3  = m_busy && ($urandom_range(0, 3) == 0);
      mrdat3 = $urandom;
      #1;
      exp_rdy = (m_busy && mrdy3) ? (3'b001 << m_gnt) : 3'b000;
      n_tests++;
      if (mval3 !== m_busy || gid3 !== 2'(m_gnt)) begin
        n_fail++; $display("FAIL rnd_state c%0d: val=%b gnt=%0d required %b %0d", c, mval3, gid3, m_busy, m_gnt);
      end
      n_tests++;
      if (r3 !== exp_rdy || srdat3 !== mrdat3) begin
        n_fail++; $display("FAIL rnd_rdy c%0d: rdy=%b rdat=%h required %b %h", c, r3, srdat3, exp_rdy, mrdat3);
      end
      if (m_busy) begin
        n_tests++;
        if ({madr3, mwen3, mwdat3} !== {t_adr[m_gnt], t_wen[m_gnt], t_wdat[m_gnt]}) begin
          n_fail++; $display("FAIL rnd_fields c%0d: adr=%h wen=%h wdat=%h required %h %h %h", c,
                             madr3, mwen3, mwdat3, t_adr[m_gnt], t_wen[m_gnt], t_wdat[m_gnt]);
        end
      end
      if (!m_busy) begin
        for (int k = 0; k < 3; k++) begin
          j = (m_ptr + k) % 3;
          if (v3[j]) begin m_gnt = j; m_busy = 1'b1; grants[j]++; break; end
        end
      end else if (mrdy3) begin
        done[m_gnt] = 1'b1;
        m_ptr  = (m_gnt + 1) % 3;
        m_busy = 1'b0;
      end
    end
    @(negedge clk);
    v3 = 3'b000; mrdy3 = 1'b0;
    $display("[TB] test_random grants m0=%0d m1=%0d m2=%0d", grants[0], grants[1], grants[2]);
  endtask

  initial begin
    v2 = '0; adr2 = '0; wen2 = '0; wdat2 = '0; mrdy2 = 1'b0; mrdat2 = '0;
    v3 = '0; adr3 = '0; wen3 = '0; wdat3 = '0; mrdy3 = 1'b0; mrdat3 = '0;
    test_reset();
    test_single_read();
    test_alternate();
    test_write_hold();
    test_wrap3();
    test_reset_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
